// File: rtl/fractal_sync_pkg.sv
// Shared types and helpers for the fractal synchronization tree.
package fractal_sync_pkg;

    localparam int unsigned MAX_LVL_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_WAIT_WAKE = 3'd2,
        ST_ACK       = 3'd3,
        ST_WAIT_REL  = 3'd4,
        ST_RESP      = 3'd5
    } init_state_e;

    // One-hot level code for a tree level index; all-zero when out of range.
    function automatic logic [MAX_LVL_WIDTH-1:0] lvl_onehot(input int unsigned idx,
                                                            input int unsigned width);
        logic [MAX_LVL_WIDTH-1:0] oh;
        oh = '0;
        if (idx < width) begin
            oh = MAX_LVL_WIDTH'(1) << idx;
        end
        return oh;
    endfunction

    // True when the level index addresses an existing tree level.
    function automatic logic lvl_in_range(input int unsigned idx, input int unsigned width);
        return idx < width;
    endfunction

endpackage

// File: rtl/fractal_if.sv
// Point-to-point link between an initiator (master) and a tree node slave port.
interface fractal_if #(
    parameter int unsigned LVL_WIDTH = 1
);
    logic [LVL_WIDTH-1:0] level;
    logic                 sync;
    logic                 ack;
    logic                 wake;
    logic                 error;

    modport mst_port (output level, sync, ack, input wake, error);
    modport slv_port (input level, sync, ack, output wake, error);
endinterface

// File: rtl/fractal_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module fractal_sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Count up while enabled, stick at the all-ones value.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (en_i && (cnt_o != CNT_MAX)) begin
            cnt_o <= cnt_o + CNT_WIDTH'(1);
        end
    end
endmodule

// File: rtl/fractal_sync_initiator.sv
// Leaf-side barrier initiator: drives one slave port of a fractal sync node.
module fractal_sync_initiator
    import fractal_sync_pkg::*;
#(
    parameter int unsigned LVL_WIDTH = 1,
    parameter int unsigned IDX_WIDTH = $clog2(LVL_WIDTH) + 1,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [IDX_WIDTH-1:0] req_level_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_error_o,
    output logic [CNT_WIDTH-1:0] rsp_cycles_o,
    fractal_if.mst_port          master
);
    if (LVL_WIDTH == 0 || LVL_WIDTH > MAX_LVL_WIDTH) begin : g_bad_lvl_width
        $fatal(1, "fractal_sync_initiator: LVL_WIDTH must be in 1..%0d", MAX_LVL_WIDTH);
    end

    init_state_e          state_q;
    logic [LVL_WIDTH-1:0] level_q;
    logic                 sync_q;
    logic                 ack_q;
    logic                 ready_q;
    logic                 rsp_valid_q;
    logic                 err_q;
    logic                 cnt_clr;
    logic                 cnt_en;
    logic [CNT_WIDTH-1:0] cnt;
    int unsigned          req_idx;

    assign req_idx      = 32'(req_level_i);
    assign req_ready_o  = ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_error_o  = err_q;
    assign rsp_cycles_o = cnt;
    assign master.level = level_q;
    assign master.sync  = sync_q;
    assign master.ack   = ack_q;

    // Latency counter: held at zero while idle, runs from the sync cycle until wake.
    always_comb begin
        cnt_clr = (state_q == ST_IDLE);
        cnt_en  = 1'b0;
        if (state_q == ST_SYNC) begin
            cnt_en = 1'b1;
        end else if ((state_q == ST_WAIT_WAKE) && !master.wake) begin
            cnt_en = 1'b1;
        end
    end

    fractal_sat_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_lat_cnt (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (cnt)
    );

    // Barrier sequencer with registered link and response outputs.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            sync_q      <= 1'b0;
            ack_q       <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync_q <= 1'b0;
            ack_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        ready_q <= 1'b0;
                        if (lvl_in_range(req_idx, LVL_WIDTH)) begin
                            level_q <= LVL_WIDTH'(lvl_onehot(req_idx, LVL_WIDTH));
                            sync_q  <= 1'b1;
                            err_q   <= 1'b0;
                            state_q <= ST_SYNC;
                        end else begin
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_SYNC: begin
                    state_q <= ST_WAIT_WAKE;
                end
                ST_WAIT_WAKE: begin
                    if (master.wake) begin
                        ack_q   <= 1'b1;
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    err_q   <= master.error;
                    state_q <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (!master.wake) begin
                        level_q     <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    level_q     <= '0;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fractal_sync_initiator.sv
// Directed bench: scripted node responses, timeline model of expected outputs.
module tb_fractal_sync_initiator;
    localparam int unsigned LVL_W = 2;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = 15;
    localparam int          N     = 100;

    logic             clk;
    logic             rstn;
    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_level;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_error;
    logic [CNT_W-1:0] rsp_cycles;

    fractal_if #(.LVL_WIDTH(LVL_W)) fif ();

    fractal_sync_initiator #(
        .LVL_WIDTH (LVL_W),
        .IDX_WIDTH (IDX_W),
        .CNT_WIDTH (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_level_i  (req_level),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_error_o  (rsp_error),
        .rsp_cycles_o (rsp_cycles),
        .master       (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus, indexed by the rising edge that samples it.
    bit s_valid [N];
    int s_lvl   [N];
    bit s_wake  [N];
    bit s_err   [N];
    bit s_rdy   [N];
    bit s_rstn  [N];

    // Expected outputs, indexed by the cycle following that edge.
    bit         e_ready  [N];
    bit         e_sync   [N];
    bit         e_ack    [N];
    logic [1:0] e_level  [N];
    bit         e_rvalid [N];
    bit         e_err    [N];
    int         e_cycles [N];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Valid barrier: wake first seen j edges after the sync edge, held h extra
    // cycles in release, response consumed r cycles after it appears.
    task automatic add_txn(input int e, input int lvl, input int j, input bit err,
                           input int h, input int r);
        int f;
        int g;
        f = e + 3 + j + h;
        g = f + 1 + r;
        s_valid[e] = 1'b1;
        s_lvl[e]   = lvl;
        for (int n = e + 1 + j; n < f; n++) s_wake[n] = 1'b1;
        s_err[e + 2 + j] = err;
        s_rdy[g] = 1'b1;
        for (int k = e; k < g; k++) e_ready[k] = 1'b0;
        e_sync[e]        = 1'b1;
        e_ack[e + 1 + j] = 1'b1;
        for (int k = e; k < f; k++) e_level[k] = 2'(1 << lvl);
        for (int k = f; k < g; k++) begin
            e_rvalid[k] = 1'b1;
            e_err[k]    = err;
            e_cycles[k] = (j > CMAX) ? CMAX : j;
        end
    endtask

    // Out-of-range level: immediate error response, tree untouched.
    task automatic add_oor(input int e, input int lvl, input int r);
        int g;
        g = e + 1 + r;
        s_valid[e] = 1'b1;
        s_lvl[e]   = lvl;
        s_rdy[g]   = 1'b1;
        for (int k = e; k < g; k++) begin
            e_ready[k]  = 1'b0;
            e_rvalid[k] = 1'b1;
            e_err[k]    = 1'b1;
            e_cycles[k] = 0;
        end
    endtask

    // Barrier cut short by reset asserted before edge rs for len edges.
    task automatic add_abort(input int e, input int lvl, input int rs, input int len);
        s_valid[e] = 1'b1;
        s_lvl[e]   = lvl;
        e_sync[e]  = 1'b1;
        for (int k = e; k < rs; k++) begin
            e_ready[k] = 1'b0;
            e_level[k] = 2'(1 << lvl);
        end
        for (int n = rs; n < rs + len; n++) s_rstn[n] = 1'b0;
    endtask

    task automatic check_cycle(input int n);
        chk("req_ready", n, 32'(req_ready), 32'(e_ready[n]));
        chk("sync", n, 32'(fif.sync), 32'(e_sync[n]));
        chk("ack", n, 32'(fif.ack), 32'(e_ack[n]));
        chk("level", n, 32'(fif.level), 32'(e_level[n]));
        chk("rsp_valid", n, 32'(rsp_valid), 32'(e_rvalid[n]));
        if (e_rvalid[n]) begin
            chk("rsp_error", n, 32'(rsp_error), 32'(e_err[n]));
            chk("rsp_cycles", n, 32'(rsp_cycles), 32'(e_cycles[n]));
        end
    endtask

    initial begin
        for (int n = 0; n < N; n++) begin
            s_valid[n] = 1'b0; s_lvl[n] = 0; s_wake[n] = 1'b0;
            s_err[n] = 1'b0; s_rdy[n] = 1'b0; s_rstn[n] = (n >= 3);
            e_ready[n] = 1'b1; e_sync[n] = 1'b0; e_ack[n] = 1'b0; e_level[n] = 2'b00;
            e_rvalid[n] = 1'b0; e_err[n] = 1'b0; e_cycles[n] = 0;
        end

        add_txn(5, 0, 1, 1'b0, 0, 0);       // local barrier, wake right after sync
        add_txn(12, 1, 6, 1'b0, 2, 3);      // late peer, long release, backpressure
        s_wake[13]  = 1'b1;                 // wake during sync must be ignored
        s_valid[15] = 1'b1;                 // requests while busy are not taken
        s_valid[24] = 1'b1;
        s_valid[27] = 1'b1;
        add_txn(28, 0, 2, 1'b1, 1, 0);      // tree reports error in ACK
        add_txn(37, 1, 3, 1'b0, 0, 1);      // error noise outside ACK
        s_err[39] = 1'b1; s_err[40] = 1'b1; s_err[41] = 1'b1;
        s_err[43] = 1'b1; s_err[44] = 1'b1;
        add_oor(47, 2, 1);
        add_oor(50, 3, 0);
        add_txn(53, 0, 20, 1'b0, 0, 0);     // counter saturation
        add_abort(80, 1, 85, 2);            // reset in WAIT_WAKE
        add_txn(89, 0, 1, 1'b1, 0, 0);      // fresh barrier after reset

        rstn = 1'b0; req_valid = 1'b0; req_level = '0; rsp_ready = 1'b0;
        fif.wake = 1'b0; fif.error = 1'b0;

        for (int n = 0; n < N; n++) begin
            @(negedge clk);
            req_valid = s_valid[n];
            req_level = IDX_W'(s_lvl[n]);
            fif.wake  = s_wake[n];
            fif.error = s_err[n];
            rsp_ready = s_rdy[n];
            rstn      = s_rstn[n];
            if (n > 0 && !s_rstn[n] && s_rstn[n-1]) begin
                #1;
                chk("rst_sync", n, 32'(fif.sync), 32'd0);
                chk("rst_ack", n, 32'(fif.ack), 32'd0);
                chk("rst_level", n, 32'(fif.level), 32'd0);
                chk("rst_rsp_valid", n, 32'(rsp_valid), 32'd0);
                chk("rst_req_ready", n, 32'(req_ready), 32'd1);
            end
            @(posedge clk);
            #1;
            check_cycle(n);
            if (n == 2)  chk("pin_reset_cycles", n, 32'(rsp_cycles), 32'd0);
            if (n == 5)  chk("pin_level0", n, 32'(fif.level), 32'b01);
            if (n == 9)  chk("pin_local_cycles", n, 32'(rsp_cycles), 32'd1);
            if (n == 12) chk("pin_level1", n, 32'(fif.level), 32'b10);
            if (n == 23) chk("pin_skew_cycles", n, 32'(rsp_cycles), 32'd6);
            if (n == 26) chk("pin_held_cycles", n, 32'(rsp_cycles), 32'd6);
            if (n == 34) chk("pin_tree_error", n, 32'(rsp_error), 32'd1);
            if (n == 44) chk("pin_noise_error", n, 32'(rsp_error), 32'd0);
            if (n == 47) chk("pin_oor_error", n, 32'(rsp_error), 32'd1);
            if (n == 47) chk("pin_oor_cycles", n, 32'(rsp_cycles), 32'd0);
            if (n == 76) chk("pin_sat_cycles", n, 32'(rsp_cycles), 32'd15);
            if (n == 93) chk("pin_post_reset_cycles", n, 32'(rsp_cycles), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
